// File: rtl/rgb_deser_pkg.sv
// Shared types and sizing helpers for the RGB byte-stream deserializer.
package rgb_deser_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } deser_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_pix_t;

    localparam int STAT_W = 16;

    // Width of a counter that indexes 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_COL_W = cnt_width(320);
    localparam int DEF_ROW_W = cnt_width(240);

endpackage

// File: rtl/pixel_out_reg.sv
// One-entry output register holding a pixel and its line/frame markers
// behind a valid/ready handshake.
module pixel_out_reg
    import rgb_deser_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        load_i,
    input  rgb_pix_t    pix_i,
    input  logic        sof_i,
    input  logic        sol_i,
    input  logic        eof_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [23:0] data_o,
    output logic        sof_o,
    output logic        sol_o,
    output logic        eof_o,
    output logic        stall_o
);

    logic     full_q, full_d;
    rgb_pix_t pix_q, pix_d;
    logic     sof_q, sof_d;
    logic     sol_q, sol_d;
    logic     eof_q, eof_d;

    always_comb begin
        full_d = full_q;
        pix_d  = pix_q;
        sof_d  = sof_q;
        sol_d  = sol_q;
        eof_d  = eof_q;
        // The producer only loads when not stalled, so a load always wins.
        if (load_i) begin
            full_d = 1'b1;
            pix_d  = pix_i;
            sof_d  = sof_i;
            sol_d  = sol_i;
            eof_d  = eof_i;
        end else if (ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            full_q <= 1'b0;
            pix_q  <= '0;
            sof_q  <= 1'b0;
            sol_q  <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            pix_q  <= pix_d;
            sof_q  <= sof_d;
            sol_q  <= sol_d;
            eof_q  <= eof_d;
        end
    end

    assign valid_o = full_q;
    assign data_o  = pix_q;
    assign sof_o   = sof_q;
    assign sol_o   = sol_q;
    assign eof_o   = eof_q;
    assign stall_o = full_q && !ready_i;

endmodule

// File: rtl/rgb_stream_deserializer.sv
// Packs an R,G,B byte stream into 24-bit pixels with SOF/SOL/EOF markers and
// checks frame geometry. Good/bad frame counters exist only with RGB_DESER_STATS_EN.
//
// state   | meaning
// IDLE    | waiting for s_sop; other bytes dropped
// RECV    | assembling pixels, byte index 0->1->2
// DISCARD | frame overran; drop bytes until s_eop
module rgb_stream_deserializer
    import rgb_deser_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_sop,
    input  logic        s_eop,
    output logic [23:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_sol,
    output logic        m_eof,
    output logic        err_short,
    output logic        err_long,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    deser_state_t     state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       r_q, r_d;
    logic [7:0]       g_q, g_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;

    logic     accept;
    logic     stall;
    logic     load;
    rgb_pix_t pix;
    logic     pix_sof, pix_sol, pix_eof;
    logic     good_frame;

    // Only the B byte can be blocked; it is the one that needs the output slot.
    assign s_ready = !((state_q == RECV) && (idx_q == 2'd2) && stall);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        col_d       = col_q;
        row_d       = row_q;
        r_d         = r_q;
        g_d         = g_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        load        = 1'b0;
        pix.r       = r_q;
        pix.g       = g_q;
        pix.b       = s_data;
        pix_sof     = (col_q == '0) && (row_q == '0);
        pix_sol     = (col_q == '0);
        pix_eof     = 1'b0;
        good_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && s_sop) begin
                    if (s_eop) begin
                        err_short_d = 1'b1;
                    end else begin
                        state_d = RECV;
                        r_d     = s_data;
                        idx_d   = 2'd1;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
            end

            RECV: begin
                if (accept) begin
                    if (s_sop) begin
                        // Restart: the sop byte is R of pixel 0 of the new frame.
                        err_short_d = 1'b1;
                        col_d       = '0;
                        row_d       = '0;
                        if (s_eop) begin
                            state_d = IDLE;
                        end else begin
                            r_d   = s_data;
                            idx_d = 2'd1;
                        end
                    end else if (idx_q == 2'd0) begin
                        r_d   = s_data;
                        idx_d = 2'd1;
                        if (s_eop) begin
                            err_short_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else if (idx_q == 2'd1) begin
                        g_d   = s_data;
                        idx_d = 2'd2;
                        if (s_eop) begin
                            err_short_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else begin
                        load  = 1'b1;
                        idx_d = 2'd0;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                        if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                            if (s_eop) begin
                                pix_eof    = 1'b1;
                                good_frame = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                err_long_d = 1'b1;
                                state_d    = DISCARD;
                            end
                        end else if (s_eop) begin
                            err_short_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
            end

            DISCARD: begin
                if (accept && s_eop) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            col_q       <= '0;
            row_q       <= '0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            r_q         <= r_d;
            g_q         <= g_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    pixel_out_reg u_out (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .load_i   (load),
        .pix_i    (pix),
        .sof_i    (pix_sof),
        .sol_i    (pix_sol),
        .eof_i    (pix_eof),
        .ready_i  (m_ready),
        .valid_o  (m_valid),
        .data_o   (m_data),
        .sof_o    (m_sof),
        .sol_o    (m_sol),
        .eof_o    (m_eof),
        .stall_o  (stall)
    );

`ifdef RGB_DESER_STATS_EN
    logic [STAT_W-1:0] frame_cnt_q;
    logic [STAT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (good_frame) begin
                frame_cnt_q <= frame_cnt_q + STAT_W'(1);
            end
            if (err_short_d || err_long_d) begin
                err_cnt_q <= err_cnt_q + STAT_W'(1);
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = good_frame;
    assign frame_cnt    = '0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_rgb_stream_deserializer.sv
// Scoreboard bench for rgb_stream_deserializer with a 4x2 frame geometry.
module tb_rgb_stream_deserializer;

    localparam int W = 4;
    localparam int H = 2;
`ifdef RGB_DESER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_sop = 1'b0;
    logic        s_eop = 1'b0;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_sof, m_sol, m_eof;
    logic        err_short, err_long;
    logic [15:0] frame_cnt, err_cnt;

    rgb_stream_deserializer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sop     (s_sop),
        .s_eop     (s_eop),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sof     (m_sof),
        .m_sol     (m_sol),
        .m_eof     (m_eof),
        .err_short (err_short),
        .err_long  (err_long),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [26:0] exp_q[$];
    int          n_short = 0;
    int          n_long = 0;
    bit          hold_v = 1'b0;
    logic [26:0] hold_val;
    bit          saw_block = 1'b0;
    int          exp_frames = 0;
    int          exp_errs = 0;
    int          exp_short = 0;
    int          exp_long = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [26:0] px(input logic [7:0] b, input bit sof, input bit sol, input bit eof);
        logic [7:0] g;
        logic [7:0] bl;
        g  = b + 8'd1;
        bl = b + 8'd2;
        return {sof, sol, eof, b, g, bl};
    endfunction

    task automatic push_frame(input logic [7:0] base, input int npix, input bit eof_last);
        for (int p = 0; p < npix; p++) begin
            exp_q.push_back(px(8'(base + 3 * p), p == 0, (p % W) == 0, eof_last && (p == npix - 1)));
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sop, input bit eop);
        int guard;
        guard   = 0;
        s_data  = d;
        s_sop   = sop;
        s_eop   = eop;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=blocked required=accepted byte=0x%0h", d);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] base, input int n, input int eop_at);
        for (int i = 0; i < n; i++) begin
            send(8'(base + i), i == 0, i == eop_at);
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_err_short_pulses"}, n_short, exp_short);
        chk({tag, "_err_long_pulses"}, n_long, exp_long);
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, STATS ? exp_frames : 0);
        chk({tag, "_err_cnt"}, {16'd0, err_cnt}, STATS ? exp_errs : 0);
    endtask

    always @(negedge clk) begin
        logic [26:0] cur;
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (err_short) n_short++;
            if (err_long) n_long++;
            if (m_valid) begin
                cur = {m_sof, m_sol, m_eof, m_data};
                if (hold_v) chk("stall_stable", {5'd0, cur}, {5'd0, hold_val});
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pixel actual=0x%0h required=none", cur);
                    end else begin
                        chk("pixel", {5'd0, cur}, {5'd0, exp_q.pop_front()});
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v   = 1'b1;
                    hold_val = cur;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_markers", {m_sof, m_sol, m_eof, err_short, err_long}, 0);
        chk("rst_counters", {frame_cnt, err_cnt}, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // good frame
        push_frame(8'h00, 8, 1'b1);
        send_seq(8'h00, 24, 23);
        settle();
        exp_frames = 1;
        check_status("good");

        // backpressure after the first pixel
        push_frame(8'h20, 8, 1'b1);
        fork
            send_seq(8'h20, 24, 23);
            begin
                int g;
                g = 0;
                while (!m_valid && g < 100) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                m_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (!s_ready) saw_block = 1'b1;
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        settle();
        exp_frames = 2;
        chk("bp_s_ready_dropped", saw_block, 1);
        check_status("bp");

        // sop+eop together in IDLE
        send(8'h55, 1'b1, 1'b1);
        settle();
        exp_short = 1;
        exp_errs  = 1;
        check_status("single_byte");

        // early eop on byte 13, then a good frame
        push_frame(8'h40, 4, 1'b0);
        send_seq(8'h40, 14, 13);
        settle();
        exp_short = 2;
        exp_errs  = 2;
        check_status("early_eop");
        push_frame(8'h60, 8, 1'b1);
        send_seq(8'h60, 24, 23);
        settle();
        exp_frames = 3;
        check_status("after_early");

        // overrun: 30 bytes, eop on byte 29, then a good frame
        push_frame(8'h70, 8, 1'b0);
        send_seq(8'h70, 30, 29);
        settle();
        exp_long = 1;
        exp_errs = 3;
        check_status("overrun");
        push_frame(8'h30, 8, 1'b1);
        send_seq(8'h30, 24, 23);
        settle();
        exp_frames = 4;
        check_status("after_overrun");

        // sop again on byte 7
        push_frame(8'h80, 2, 1'b0);
        for (int i = 0; i < 7; i++) send(8'(8'h80 + i), i == 0, 1'b0);
        push_frame(8'h87, 8, 1'b1);
        send_seq(8'h87, 24, 23);
        settle();
        exp_short  = 3;
        exp_errs   = 4;
        exp_frames = 5;
        check_status("sop_restart");

        // reset mid-frame with a pixel held
        push_frame(8'hA0, 2, 1'b0);
        for (int i = 0; i < 9; i++) send(8'(8'hA0 + i), i == 0, 1'b0);
        m_ready = 1'b0;
        send(8'hA9, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        chk("pre_reset_m_valid", m_valid, 1);
        chk("pre_reset_m_data", m_data, 24'hA6A7A8);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_markers", {m_sof, m_sol, m_eof, err_short, err_long}, 0);
        chk("midrst_counters", {frame_cnt, err_cnt}, 0);
        chk("midrst_s_ready", s_ready, 1);
        exp_frames = 0;
        exp_errs   = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(8'hB0 + i), 1'b0, 1'b0);
        settle();
        chk("post_reset_m_valid", m_valid, 0);
        check_status("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_stream_deserializer.md
# rgb_stream_deserializer

Converts the 8-bit Avalon-ST RGB byte stream delivered by the PCIe/Qsys subsystem (`avl_stream_rgb_data_in`) into 24-bit pixels with line/frame markers for the depth-estimation network input. It sits directly downstream of the Qsys interface wrapper, in the `clk_user_out` domain. It checks every frame against the configured geometry, flags short and long frames, and resynchronises on the next start-of-packet.

## Interface

**Parameters**
- `IMG_W`, default 320: pixels per line.
- `IMG_H`, default 240: lines per frame.

**Ports**
- `clk`, in, 1: `clk_user_out`; all logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `s_data`, in, 8: input byte. Byte order within a pixel is R, G, B.
- `s_valid`, in, 1: input byte valid.
- `s_ready`, out, 1: byte accepted when `s_valid && s_ready`.
- `s_sop`, in, 1: first byte of a frame.
- `s_eop`, in, 1: last byte of a frame.
- `m_data`, out, 24: pixel, laid out as {R,G,B}, with R in bits [23:16].
- `m_valid`, out, 1: pixel valid.
- `m_ready`, in, 1: downstream accepts the pixel.
- `m_sof`, out, 1: pixel (0,0).
- `m_sol`, out, 1: first pixel of a line.
- `m_eof`, out, 1: pixel (IMG_W-1, IMG_H-1) of a correctly terminated frame.
- `err_short`, out, 1: one-cycle pulse when a frame ends early.
- `err_long`, out, 1: one-cycle pulse when a frame overruns.
- `frame_cnt`, out, 16: count of good frames (see Configuration).
- `err_cnt`, out, 16: count of bad frames (see Configuration).

## Operation

- **FSM states.**
  - IDLE: `s_ready`=1. Bytes without `s_sop` are dropped. A byte with `s_sop` is taken as R of pixel 0 and the FSM goes to RECV.
  - RECV: the byte index counts 0→1→2→0. The column and row counters advance on every completed pixel.
  - DISCARD: `s_ready`=1, all bytes are dropped. A byte with `s_eop` returns the FSM to IDLE.
- **Pixel emission.** A pixel is written to a single output register when its B byte is accepted.
  - `m_sof` = (col==0 && row==0).
  - `m_sol` = (col==0).
  - `m_eof` is set only when that B byte also carries `s_eop`.
- **Backpressure.** `s_ready` = 0 only when in RECV, byte index = 2, and `m_valid && !m_ready`. R and G bytes are always accepted.
- **Good frame.** `s_eop` arrives on the B byte of pixel IMG_W·IMG_H−1. The pixel is emitted with `m_eof`=1, `frame_cnt` increments, and the FSM goes to IDLE.
- **Early `s_eop`.** Any other `s_eop` while in RECV pulses `err_short`. The partial pixel is dropped and the FSM goes to IDLE.
- **`s_sop` while in RECV**, including on byte 0 of a pixel:
  - `err_short` pulses.
  - The partial pixel is dropped.
  - The counters reload, and the byte becomes R of pixel 0 of a new frame.
- **Overrun.** The last pixel's B byte arrives without `s_eop`. The pixel is emitted with `m_eof`=0, `err_long` pulses, and the FSM goes to DISCARD.
- **Single-byte frame.** A byte with `s_sop` and `s_eop` together in IDLE pulses `err_short` and the FSM stays in IDLE.
- **Counter wrap.** `frame_cnt` and `err_cnt` wrap from 0xFFFF to 0. `err_cnt` increments once per `err_short` or `err_long` pulse.

## Timing

- **Reset values.** FSM=IDLE, counters=0.
  - Outputs: `m_valid`=0, `m_data`=0, `m_sof`/`m_sol`/`m_eof`=0, `err_*`=0, `frame_cnt`/`err_cnt`=0.
  - `s_ready`=1 (combinational from IDLE).
- **Reset mid-frame** clears all state immediately, and any held pixel is lost.
- **Latency.** `m_valid` rises the cycle after the B byte handshake.
- **Throughput.** One byte per clock, i.e. one pixel per 3 clocks when `m_ready`=1.
- **Output stability.** `m_data` and the markers hold stable while `m_valid && !m_ready`.
- **Error pulses.** `err_short` and `err_long` are registered, asserted in the cycle after the offending handshake, for exactly one cycle.

## Configuration

- `RGB_DESER_STATS_EN` defined: the `frame_cnt` and `err_cnt` registers are implemented.
- Not defined: both ports are tied to 0 and no counter flops are synthesised. The error pulses and all other behaviour are unchanged.

## Structure

- Package `rgb_deser_pkg`:
  - FSM state enum `deser_state_t` {IDLE, RECV, DISCARD}.
  - Pixel struct `rgb_pix_t` {r,g,b}.
  - `clog2`-derived counter width constants.
- Sub-module `pixel_out_reg`: a one-entry output register with the valid/ready handshake. It holds the pixel and markers and provides the `full && !m_ready` stall term.

## Test plan

All directed tests run with `IMG_W`=4, `IMG_H`=2, i.e. 24 bytes per frame.

- **Good frame:** 24 bytes 0x00..0x17 with `s_sop` on byte 0 and `s_eop` on byte 23, `m_ready`=1.
  - Required: 8 pixels, first 0x000102 with `m_sof`=1 and `m_sol`=1.
  - Pixel 4 is 0x0C0D0E with `m_sol`=1.
  - Last pixel is 0x151617 with `m_eof`=1; `frame_cnt`=1.
- **Backpressure:** `m_ready` held 0 for 10 cycles after the first pixel.
  - Required: `s_ready` drops on the next B byte.
  - No pixel is lost or duplicated, and `m_data` stays stable while stalled.
- **Early `s_eop`:** `s_eop` on byte 13.
  - Required: 4 pixels emitted, `err_short` pulses once, and `err_cnt`=1.
  - A following good frame decodes correctly.
- **Overrun:** 30 bytes, `s_eop` on byte 29.
  - Required: 8 pixels with `m_eof`=0 throughout and `err_long` pulsing after byte 23.
  - Bytes 24–29 are dropped, then the FSM is back in IDLE.
- **`s_sop` mid-pixel:** `s_sop` again on byte 7.
  - Required: `err_short` pulses and 2 pixels come from the first frame.
  - Byte 7 is R of the new frame's pixel 0, which is emitted with `m_sof`=1.
- **Reset mid-frame:** `reset_n` low after byte 10 while `m_valid`=1.
  - Required: all outputs return to their reset values.
  - Bytes without `s_sop` are ignored afterwards.
